// File: rtl/join_result_unpacker.sv
// join_result_unpacker: takes one packed multi-lane beat of joined tuples and
// serialises its fully-kept lanes, lowest lane first, onto a one-tuple-per-cycle
// valid/ready stream. It also flags partially-kept lanes, counts the delivered
// tuples and signals when the result set has been drained.
module join_result_unpacker #(
   parameter int LANES      = 8,
   parameter int TUPLE_BITS = 128,
   parameter int CNT_BITS   = 32
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [LANES*TUPLE_BITS-1:0]   in_data,
   input  logic [LANES*TUPLE_BITS/8-1:0] in_keep,
   input  logic                          in_valid,
   input  logic                          in_last,
   output logic                          in_ready,
   output logic [TUPLE_BITS-1:0]         out_data,
   output logic [2:0]                    out_lane,
   output logic                          out_valid,
   output logic                          out_last,
   input  logic                          out_ready,
   output logic [CNT_BITS-1:0]           result_count,
   output logic                          done,
   output logic                          keep_error
);

   localparam int KB = TUPLE_BITS / 8;

   typedef enum logic [1:0] {IDLE, DRAIN, FINISHED} state_t;

   state_t                        state_q, state_d;
   logic [LANES*TUPLE_BITS-1:0]   data_q, data_d;
   logic [LANES-1:0]              pending_q, pending_d;
   logic                          last_q, last_d;
   logic [CNT_BITS-1:0]           cnt_q, cnt_d;
   logic                          kerr_q, kerr_d;

   logic [LANES-1:0]              lane_full, lane_part;
   logic [2:0]                    lane_idx;
   logic                          one_left, take, accept;

   // Classify each incoming lane's keep slice: full -> deliver, partial -> malformed.
   for (genvar g = 0; g < LANES; g++) begin : g_cls
      assign lane_full[g] = &in_keep[g*KB +: KB];
      assign lane_part[g] = (|in_keep[g*KB +: KB]) && !lane_full[g];
   end

   // Output side: lowest pending lane is presented; everything comes from registers.
   always_comb begin
      lane_idx = '0;
      for (int k = LANES - 1; k >= 0; k--)
         if (pending_q[k]) lane_idx = 3'(k);
      out_valid = |pending_q;
      out_data  = out_valid ? data_q[lane_idx*TUPLE_BITS +: TUPLE_BITS] : '0;
      out_lane  = lane_idx;
      one_left  = out_valid && ((pending_q & (pending_q - LANES'(1))) == '0);
      out_last  = last_q && one_left;
      in_ready  = !out_valid || (one_left && out_ready);
      take      = out_valid && out_ready;
      accept    = in_valid && in_ready;
   end

   // Next state: retire the presented tuple, then let an accepted beat replace the mask.
   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      pending_d = pending_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      kerr_d    = kerr_q;
      if (take) begin
         pending_d[lane_idx] = 1'b0;
         if (cnt_q != '1) cnt_d = cnt_q + CNT_BITS'(1);
      end
      if (state_q == DRAIN && take && pending_d == '0)
         state_d = last_q ? FINISHED : IDLE;
      if (accept) begin
         data_d    = in_data;
         pending_d = lane_full;
         last_d    = in_last;
         kerr_d    = kerr_q | (|lane_part);
         // A new result set starts counting from zero.
         if (state_q == FINISHED) cnt_d = '0;
         if (|lane_full)   state_d = DRAIN;
         else if (in_last) state_d = FINISHED;
         else              state_d = IDLE;
      end
   end

   // State and beat registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         data_q    <= '0;
         pending_q <= '0;
         last_q    <= 1'b0;
         cnt_q     <= '0;
         kerr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         pending_q <= pending_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         kerr_q    <= kerr_d;
      end
   end

   assign result_count = cnt_q;
   assign done         = (state_q == FINISHED);
   assign keep_error   = kerr_q;

endmodule

// File: tb/tb_join_result_unpacker.sv
// Bench for join_result_unpacker: directed scenarios plus random beats, all
// checked every cycle against a tuple-queue model of the result stream.
module tb_join_result_unpacker;

   localparam int LANES = 8;
   localparam int TBITS = 128;
   localparam int KB    = 16;

   logic                    clk = 1'b0;
   logic                    resetn = 1'b0;
   logic [LANES*TBITS-1:0]  in_data = '0;
   logic [LANES*KB-1:0]     in_keep = '0;
   logic                    in_valid = 1'b0;
   logic                    in_last = 1'b0;
   logic                    in_ready;
   logic [TBITS-1:0]        out_data;
   logic [2:0]              out_lane;
   logic                    out_valid;
   logic                    out_last;
   logic                    out_ready = 1'b0;
   logic [31:0]             result_count;
   logic                    done;
   logic                    keep_error;

   join_result_unpacker dut (
      .clk(clk), .resetn(resetn), .in_data(in_data), .in_keep(in_keep),
      .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_data(out_data), .out_lane(out_lane), .out_valid(out_valid),
      .out_last(out_last), .out_ready(out_ready), .result_count(result_count),
      .done(done), .keep_error(keep_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [TBITS-1:0] d;
      logic [2:0]       lane;
      bit               last;
   } tup_t;

   tup_t q[$];          // tuples still owed by the DUT, in delivery order
   int   m_cnt;
   bit   m_done, m_kerr, m_last;
   bit   acc_flag;
   int   rdy_mode;      // 0: ready, 1: random, 2: toggle, 3: stalled
   int   cyc;
   int   errors = 0;
   int   checks = 0;

   task automatic model_reset();
      q.delete();
      m_cnt = 0; m_done = 0; m_kerr = 0; m_last = 0;
   endtask

   function automatic logic [LANES*TBITS-1:0] rand_data();
      logic [LANES*TBITS-1:0] d;
      for (int i = 0; i < LANES*TBITS/32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [LANES*KB-1:0] keep_of(input logic [LANES-1:0] m);
      logic [LANES*KB-1:0] k;
      for (int i = 0; i < LANES; i++) k[i*KB +: KB] = m[i] ? 16'hFFFF : 16'h0000;
      return k;
   endfunction

   // One clock: compare DUT against the model mid-cycle, then advance the model.
   task automatic cycle();
      bit m_rdy, acc;
      int hi;
      tup_t t;
      logic [KB-1:0] ks;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         2:       out_ready = (cyc % 2 == 0);
         default: out_ready = 1'b0;
      endcase
      @(negedge clk);
      m_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
      checks++;
      if (in_ready !== m_rdy) begin
         errors++; $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, m_rdy);
      end
      checks++;
      if (out_valid !== (q.size() != 0)) begin
         errors++; $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
         checks++;
         if (out_data !== q[0].d || out_lane !== q[0].lane || out_last !== q[0].last) begin
            errors++;
            $display("FAIL tuple cyc=%0d got lane=%0d last=%b data=%h exp lane=%0d last=%b data=%h",
                     cyc, out_lane, out_last, out_data, q[0].lane, q[0].last, q[0].d);
         end
      end else begin
         checks++;
         if (out_last !== 1'b0) begin
            errors++; $display("FAIL out_last_idle cyc=%0d got=%b exp=0", cyc, out_last);
         end
      end
      checks++;
      if (result_count !== 32'(m_cnt)) begin
         errors++; $display("FAIL result_count cyc=%0d got=%0d exp=%0d", cyc, result_count, m_cnt);
      end
      checks++;
      if (done !== m_done || keep_error !== m_kerr) begin
         errors++;
         $display("FAIL done/keep_error cyc=%0d got=%b/%b exp=%b/%b", cyc, done, keep_error, m_done, m_kerr);
      end
      acc = in_valid && m_rdy;
      if (out_ready && q.size() != 0) begin
         void'(q.pop_front());
         m_cnt++;
         if (q.size() == 0 && m_last && !acc) m_done = 1;
      end
      if (acc) begin
         if (m_done) m_cnt = 0;
         m_done = 0;
         m_last = in_last;
         hi = -1;
         for (int k = 0; k < LANES; k++) if (in_keep[k*KB +: KB] == 16'hFFFF) hi = k;
         for (int k = 0; k < LANES; k++) begin
            ks = in_keep[k*KB +: KB];
            if (ks == 16'hFFFF) begin
               t.d = in_data[k*TBITS +: TBITS];
               t.lane = 3'(k);
               t.last = in_last && (k == hi);
               q.push_back(t);
            end else if (ks != 16'h0000) begin
               m_kerr = 1;
            end
         end
         if (in_last && hi < 0) m_done = 1;
      end
      acc_flag = acc;
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic send_beat(input logic [LANES*TBITS-1:0] d, input logic [LANES*KB-1:0] k, input bit last);
      int n;
      in_data = d; in_keep = k; in_last = last; in_valid = 1'b1;
      n = 0;
      do begin cycle(); n++; end while (!acc_flag && n < 200);
      checks++;
      if (!acc_flag) begin errors++; $display("FAIL accept_timeout got=0 exp=1"); end
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic drain();
      int n;
      in_valid = 1'b0;
      n = 0;
      while (q.size() != 0 && n < 500) begin cycle(); n++; end
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL drain_timeout left=%0d exp=0", q.size()); end
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      @(negedge clk) resetn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      in_valid = 1'b0; out_ready = 1'b1; resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
         errors++; $display("FAIL reset_hs got rdy=%b vld=%b last=%b exp 1/0/0", in_ready, out_valid, out_last);
      end
      checks++;
      if (out_data !== '0 || out_lane !== 3'd0) begin
         errors++; $display("FAIL reset_data got lane=%0d data=%h exp 0/0", out_lane, out_data);
      end
      checks++;
      if (result_count !== 32'd0 || done !== 1'b0 || keep_error !== 1'b0) begin
         errors++; $display("FAIL reset_status got cnt=%0d done=%b kerr=%b exp 0/0/0", result_count, done, keep_error);
      end
      model_reset();
      @(negedge clk) resetn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_full_beat();
      rdy_mode = 0;
      send_beat(rand_data(), keep_of(8'hFF), 1'b0);
      repeat (7) cycle();
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_lane !== 3'd7) begin
         errors++; $display("FAIL full_last_lane got rdy=%b lane=%0d exp 1/7", in_ready, out_lane);
      end
      cycle();
      checks++;
      if (result_count !== 32'd8 || out_valid !== 1'b0) begin
         errors++; $display("FAIL full_count got cnt=%0d vld=%b exp 8/0", result_count, out_valid);
      end
   endtask

   task automatic test_sparse_last();
      rdy_mode = 0;
      send_beat(rand_data(), keep_of(8'b0101_0010), 1'b1);
      drain();
      checks++;
      if (done !== 1'b1 || result_count !== 32'd11) begin
         errors++; $display("FAIL sparse_done got done=%b cnt=%0d exp 1/11", done, result_count);
      end
      cycle();
   endtask

   task automatic test_partial_keep();
      logic [LANES*KB-1:0] k;
      rdy_mode = 0;
      k = keep_of(8'hFF);
      k[2*KB +: KB] = 16'h00FF;
      send_beat(rand_data(), k, 1'b0);
      drain();
      checks++;
      if (keep_error !== 1'b1 || result_count !== 32'd7) begin
         errors++; $display("FAIL partial got kerr=%b cnt=%0d exp 1/7", keep_error, result_count);
      end
      send_beat(rand_data(), keep_of(8'hFF), 1'b0);
      send_beat(rand_data(), keep_of(8'h3C), 1'b0);
      drain();
      checks++;
      if (keep_error !== 1'b1) begin
         errors++; $display("FAIL partial_sticky got kerr=%b exp 1", keep_error);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] c0;
      rdy_mode = 2;
      c0 = result_count;
      send_beat(rand_data(), keep_of(8'hFF), 1'b0);
      send_beat(rand_data(), keep_of(8'hFF), 1'b0);
      drain();
      checks++;
      if (result_count !== c0 + 32'd16) begin
         errors++; $display("FAIL b2b_count got=%0d exp=%0d", result_count, c0 + 32'd16);
      end
   endtask

   task automatic test_empty_last();
      do_reset();
      rdy_mode = 0;
      send_beat(rand_data(), keep_of(8'h1F), 1'b0);
      send_beat(rand_data(), '0, 1'b1);
      drain();
      cycle();
      checks++;
      if (done !== 1'b1 || result_count !== 32'd5) begin
         errors++; $display("FAIL empty_last got done=%b cnt=%0d exp 1/5", done, result_count);
      end
      send_beat(rand_data(), keep_of(8'h03), 1'b0);
      checks++;
      if (done !== 1'b0 || result_count !== 32'd0) begin
         errors++; $display("FAIL new_set got done=%b cnt=%0d exp 0/0", done, result_count);
      end
      drain();
      checks++;
      if (result_count !== 32'd2) begin
         errors++; $display("FAIL new_set_count got=%0d exp=2", result_count);
      end
   endtask

   task automatic test_reset_mid();
      rdy_mode = 3;
      send_beat(rand_data(), keep_of(8'h0F), 1'b0);
      cycle();
      resetn = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || result_count !== 32'd0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_mid got vld=%b cnt=%0d rdy=%b exp 0/0/1", out_valid, result_count, in_ready);
      end
      model_reset();
      @(negedge clk) resetn = 1'b1;
      @(posedge clk); #1;
      rdy_mode = 0;
      repeat (3) cycle();
   endtask

   task automatic test_random();
      logic [LANES*KB-1:0] k;
      int r;
      rdy_mode = 1;
      for (int b = 0; b < 40; b++) begin
         for (int l = 0; l < LANES; l++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      k[l*KB +: KB] = 16'hFFFF;
            else if (r < 8) k[l*KB +: KB] = 16'h0000;
            else            k[l*KB +: KB] = 16'($urandom_range(1, 16'hFFFE));
         end
         send_beat(rand_data(), k, $urandom_range(0, 3) == 0);
      end
      drain();
      repeat (2) cycle();
   endtask

   initial begin
      cyc = 0;
      rdy_mode = 0;
      model_reset();
      test_reset();
      test_full_beat();
      test_sparse_last();
      test_partial_keep();
      test_back_to_back();
      test_empty_last();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
